// File: rtl/gpio_link_pkg.sv
// Shared definitions for the inter-board GPIO messenger link.
// Frame levels, receiver states and link timing constants.
package gpio_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int CLK_DIVIDE        = 5000;
  // Roughly three peer clock periods at the shared divide.
  localparam int DEFAULT_TIMEOUT   = 6 * CLK_DIVIDE;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gpio_serial_receiver_if.sv
// Link bundle: raw peer lines in, recovered edge/data out.
// master drives the pins, sync recovers, slave consumes.
interface gpio_serial_receiver_if;

  logic gpio_clk;
  logic gpio_data;
  logic rise;
  logic data;

  modport master (
    output gpio_clk,
    output gpio_data
  );

  modport sync (
    input  gpio_clk,
    input  gpio_data,
    output rise,
    output data
  );

  modport slave (
    input rise,
    input data
  );

endinterface

// File: rtl/gpio_edge_sync.sv
// Synchronizes peer clock/data and emits one pulse per clock rise.
// Data rides a matched-depth chain so it stays aligned with the edge.
module gpio_edge_sync
  import gpio_link_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  gpio_serial_receiver_if.sync   lnk
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   hist_q;
  logic                   rise_q;
  logic                   data_q;
  logic                   rise_d;

  assign rise_d = clk_sync_q[SYNC_STAGES-1] & ~hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      dat_sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      hist_q     <= IDLE_LEVEL;
      rise_q     <= 1'b0;
      data_q     <= IDLE_LEVEL;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], lnk.gpio_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], lnk.gpio_data};
      hist_q     <= clk_sync_q[SYNC_STAGES-1];
      rise_q     <= rise_d;
      data_q     <= dat_sync_q[SYNC_STAGES-1];
    end
  end

  assign lnk.rise = rise_q;
  assign lnk.data = data_q;

endmodule

// File: rtl/gpio_serial_receiver.sv
// Receive end of the GPIO messenger link: start/data/stop framing,
// byte hand-off pulse, bad-stop and stalled-link detection.
module gpio_serial_receiver
  import gpio_link_pkg::*;
#(
  parameter int DATA_BITS      = DEFAULT_DATA_BITS,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                 FPGA_clock,
  input  logic                 reset,
  input  logic                 gpio_clock_in,
  input  logic                 gpio_data_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int CW = cnt_width(DATA_BITS);

  gpio_serial_receiver_if lnk ();

  assign lnk.gpio_clk  = gpio_clock_in;
  assign lnk.gpio_data = gpio_data_in;

  gpio_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (FPGA_clock),
    .rst_i (reset),
    .lnk   (lnk.sync)
  );

  rx_state_e              state_q;
  logic [CW-1:0]          bit_cnt_q;
  logic [31:0]            timer_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   frame_error_q;
  logic                   timer_hit;

  // >= keeps the timer from ever wrapping.
  assign timer_hit = timer_q >= 32'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge FPGA_clock) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      timer_q       <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (lnk.rise && lnk.data == START_BIT) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (lnk.rise) begin
            timer_q <= '0;
            shift_q <= {lnk.data, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
              state_q <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (timer_hit) begin
            frame_error_q <= 1'b1;
            state_q       <= IDLE;
            timer_q       <= '0;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        STOP: begin
          if (lnk.rise) begin
            timer_q <= '0;
            state_q <= IDLE;
            if (lnk.data == STOP_BIT) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              frame_error_q <= 1'b1;
            end
          end else if (timer_hit) begin
            frame_error_q <= 1'b1;
            state_q       <= IDLE;
            timer_q       <= '0;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_gpio_serial_receiver.sv
// Randomized self-checking bench for gpio_serial_receiver.
// Frames are decoded by a behavioural bit-list model.
module tb_gpio_serial_receiver;
  import gpio_link_pkg::*;

  localparam int DW = 8;
  localparam int TO = 100;
  localparam int LAT = 4;

  typedef struct {
    int          c;
    logic [DW-1:0] d;
  } rx_ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_error;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_seen = 0;

  rx_ev_t rx_q[$];
  int     err_q[$];
  logic   prev_v = 1'b0;
  logic   prev_e = 1'b0;

  gpio_serial_receiver_if pins ();
  assign pins.rise = 1'b0;
  assign pins.data = 1'b0;

  gpio_serial_receiver #(
    .DATA_BITS      (DW),
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (2)
  ) dut (
    .FPGA_clock    (clk),
    .reset         (rst),
    .gpio_clock_in (pins.gpio_clk),
    .gpio_data_in  (pins.gpio_data),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .frame_error   (frame_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_q.push_back('{cyc, rx_data});
    if (frame_error === 1'b1) err_q.push_back(cyc);
    if (busy === 1'b1) busy_seen = 1;
    if (rx_valid === 1'b1 || frame_error === 1'b1) begin
      checks++;
      if ((rx_valid && frame_error) || (rx_valid && prev_v)
          || (frame_error && prev_e)) begin
        errors++;
        $display("FAIL pulse_shape: valid=%b err=%b prev_v=%b prev_e=%b, need single exclusive pulses",
                 rx_valid, frame_error, prev_v, prev_e);
      end
    end
    prev_v = (rx_valid === 1'b1);
    prev_e = (frame_error === 1'b1);
  end

  // Model: start must be 0, stop must be 1, payload is LSB first.
  function automatic int model_decode(input logic bits[], input int n);
    int v = 0;
    if (bits[0] !== START_BIT || bits[n-1] !== STOP_BIT) return -1;
    for (int i = 0; i < DW; i++) v += int'(bits[i+1]) * (1 << i);
    return v;
  endfunction

  task automatic clear_obs();
    rx_q.delete();
    err_q.delete();
    busy_seen = 0;
  endtask

  task automatic drive_bit(input logic b, input int h, output int rise_c);
    @(posedge clk); #1;
    pins.gpio_clk  = 1'b0;
    pins.gpio_data = b;
    repeat (h) @(posedge clk);
    #1;
    pins.gpio_clk = 1'b1;
    rise_c = cyc;
    repeat (h - 1) @(posedge clk);
  endtask

  task automatic send_bits(input logic bits[], input int n, input int h,
                           output int last_rise);
    for (int i = 0; i < n; i++) drive_bit(bits[i], h, last_rise);
  endtask

  task automatic make_frame(input logic [DW-1:0] b, input logic stop,
                            output logic bits[]);
    bits = new[DW + 2];
    bits[0] = START_BIT;
    for (int i = 0; i < DW; i++) bits[i+1] = b[i];
    bits[DW+1] = stop;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_one_byte(input string nm, input int exp, input int sr);
    checks++;
    if (rx_q.size() !== 1) begin
      errors++;
      $display("FAIL %s_count: got %0d valid pulses, need 1", nm, rx_q.size());
    end else begin
      checks++;
      if (int'(rx_q[0].d) !== exp) begin
        errors++;
        $display("FAIL %s_data: got %h, need %h", nm, rx_q[0].d, exp);
      end
      checks++;
      if (rx_q[0].c - sr !== LAT) begin
        errors++;
        $display("FAIL %s_latency: got %0d, need %0d", nm, rx_q[0].c - sr, LAT);
      end
    end
    checks++;
    if (err_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_noerr: got %0d error pulses, need 0", nm, err_q.size());
    end
  endtask

  task automatic test_reset();
    pins.gpio_clk  = 1'b1;
    pins.gpio_data = 1'b1;
    rst = 1'b1;
    settle(3);
    checks++;
    if ({rx_data, rx_valid, frame_error, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b e=%b busy=%b, need all 0",
               rx_data, rx_valid, frame_error, busy);
    end
    rst = 1'b0;
    settle(5);
  endtask

  task automatic test_single_a5();
    logic bits[];
    int sr;
    int exp;
    clear_obs();
    make_frame(8'hA5, 1'b1, bits);
    exp = model_decode(bits, DW + 2);
    send_bits(bits, DW + 2, 20, sr);
    settle(10);
    check_one_byte("a5", exp, sr);
    checks++;
    if (busy !== 1'b0 || busy_seen !== 1) begin
      errors++;
      $display("FAIL a5_busy: got busy=%b seen=%0d, need 0 and seen", busy, busy_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic b0[];
    logic b1[];
    int sr;
    clear_obs();
    make_frame(8'h00, 1'b1, b0);
    make_frame(8'hFF, 1'b1, b1);
    send_bits(b0, DW + 2, 12, sr);
    send_bits(b1, DW + 2, 12, sr);
    settle(10);
    checks++;
    if (rx_q.size() !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d, need 2", rx_q.size());
    end else begin
      checks++;
      if (int'(rx_q[0].d) !== model_decode(b0, DW + 2)
          || int'(rx_q[1].d) !== model_decode(b1, DW + 2)) begin
        errors++;
        $display("FAIL b2b_data: got %h %h, need 00 ff", rx_q[0].d, rx_q[1].d);
      end
    end
  endtask

  task automatic test_bad_stop();
    logic bits[];
    int sr;
    clear_obs();
    make_frame(8'h77, 1'b1, bits);
    send_bits(bits, DW + 2, 16, sr);
    make_frame(8'h3C, 1'b0, bits);
    send_bits(bits, DW + 2, 16, sr);
    settle(10);
    checks++;
    if (model_decode(bits, DW + 2) != -1 || err_q.size() !== 1) begin
      errors++;
      $display("FAIL badstop_err: got %0d error pulses, need 1", err_q.size());
    end else begin
      checks++;
      if (err_q[0] - sr !== LAT) begin
        errors++;
        $display("FAIL badstop_lat: got %0d, need %0d", err_q[0] - sr, LAT);
      end
    end
    checks++;
    if (rx_q.size() !== 1 || rx_data !== 8'h77 || busy !== 1'b0) begin
      errors++;
      $display("FAIL badstop_hold: got n=%0d data=%h busy=%b, need 1 77 0",
               rx_q.size(), rx_data, busy);
    end
  endtask

  task automatic test_timeout();
    logic bits[];
    int sr;
    int lr;
    int waited = 0;
    clear_obs();
    make_frame(8'h05, 1'b1, bits);
    send_bits(bits, 4, 20, lr);
    @(posedge clk); #1;
    pins.gpio_clk = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_busy: got %b, need 1", busy);
    end
    while (err_q.size() == 0 && waited < 4 * TO) begin
      @(posedge clk);
      waited++;
    end
    #1;
    checks++;
    if (err_q.size() !== 1) begin
      errors++;
      $display("FAIL timeout_fire: got %0d error pulses, need 1", err_q.size());
    end else begin
      checks++;
      if (err_q[0] - lr !== LAT + TO) begin
        errors++;
        $display("FAIL timeout_time: got %0d, need %0d", err_q[0] - lr, LAT + TO);
      end
    end
    checks++;
    if (rx_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_discard: got n=%0d busy=%b, need 0 0", rx_q.size(), busy);
    end
    clear_obs();
    make_frame(8'h81, 1'b1, bits);
    send_bits(bits, DW + 2, 20, sr);
    settle(10);
    check_one_byte("after_to", 8'h81, sr);
  endtask

  task automatic test_edge_at_limit();
    logic bits[];
    int sr;
    clear_obs();
    make_frame(8'hC3, 1'b1, bits);
    send_bits(bits, DW + 2, TO / 2, sr);
    settle(10);
    check_one_byte("limit_ok", 8'hC3, sr);
    clear_obs();
    make_frame(8'hFF, 1'b1, bits);
    send_bits(bits, DW + 2, TO / 2 + 1, sr);
    settle(10);
    checks++;
    if (err_q.size() !== 1 || rx_q.size() !== 0) begin
      errors++;
      $display("FAIL limit_over: got err=%0d rx=%0d, need 1 0", err_q.size(), rx_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic bits[];
    int sr;
    clear_obs();
    make_frame(8'h5A, 1'b1, bits);
    send_bits(bits, 6, 20, sr);
    settle(6);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_busy: got %b, need 1", busy);
    end
    rst = 1'b1;
    settle(1);
    checks++;
    if ({rx_data, rx_valid, frame_error, busy} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got data=%h v=%b e=%b busy=%b, need all 0",
               rx_data, rx_valid, frame_error, busy);
    end
    rst = 1'b0;
    settle(10);
    clear_obs();
    send_bits(bits, DW + 2, 20, sr);
    settle(10);
    check_one_byte("midrst_5a", model_decode(bits, DW + 2), sr);
  endtask

  task automatic test_idle_line();
    int r;
    clear_obs();
    for (int i = 0; i < 50; i++) drive_bit(IDLE_LEVEL, 20, r);
    settle(10);
    checks++;
    if (rx_q.size() !== 0 || err_q.size() !== 0 || busy_seen !== 0) begin
      errors++;
      $display("FAIL idle_quiet: got rx=%0d err=%0d busy_seen=%0d, need 0 0 0",
               rx_q.size(), err_q.size(), busy_seen);
    end
  endtask

  task automatic test_random();
    logic bits[];
    int sr;
    int exp_q[$];
    int exp_err = 0;
    int v;
    clear_obs();
    for (int f = 0; f < 12; f++) begin
      logic [DW-1:0] b = DW'($urandom);
      logic stop = ($urandom_range(0, 3) != 0);
      int h = $urandom_range(4, 40);
      int idl = $urandom_range(0, 2);
      for (int k = 0; k < idl; k++) drive_bit(IDLE_LEVEL, h, sr);
      make_frame(b, stop, bits);
      v = model_decode(bits, DW + 2);
      if (v < 0) exp_err++;
      else exp_q.push_back(v);
      send_bits(bits, DW + 2, h, sr);
    end
    settle(10);
    checks++;
    if (rx_q.size() !== exp_q.size() || err_q.size() !== exp_err) begin
      errors++;
      $display("FAIL rand_counts: got rx=%0d err=%0d, need rx=%0d err=%0d",
               rx_q.size(), err_q.size(), exp_q.size(), exp_err);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (int'(rx_q[i].d) !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_data[%0d]: got %h, need %h", i, rx_q[i].d, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_bad_stop();
    test_timeout();
    test_edge_at_limit();
    test_reset_mid_frame();
    test_idle_line();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
